// File: rtl/msk_g16_share_encoder_pkg.sv
// ----------------------------------------------------------------------------
// msk_enc_pkg
//   Shared constants and helper functions for the masked G(16) share encoder:
//   xorshift32 shift amounts, the per-share seed-spread constant, the
//   zero-state fallback, and the xorshift32 step / seed-derivation functions.
// ----------------------------------------------------------------------------
package msk_enc_pkg;

    localparam int unsigned XS_SHIFT_A = 13;
    localparam int unsigned XS_SHIFT_B = 17;
    localparam int unsigned XS_SHIFT_C = 5;

    localparam logic [31:0] SEED_SPREAD   = 32'h9E3779B9;
    localparam logic [31:0] ZERO_FALLBACK = 32'h0000_0001;

    function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << XS_SHIFT_A);
        y = y ^ (y >> XS_SHIFT_B);
        y = y ^ (y << XS_SHIFT_C);
        return y;
    endfunction

    // xorshift32 has an all-zero fixed point, so a zero seed is replaced.
    function automatic logic [31:0] xorshift32_seed(input logic [31:0] seed,
                                                    input logic [31:0] k);
        logic [31:0] v;
        v = seed ^ (k * SEED_SPREAD);
        return (v == '0) ? ZERO_FALLBACK : v;
    endfunction

endpackage

// File: rtl/msk_g16_share_encoder_xorshift32.sv
// ----------------------------------------------------------------------------
// msk_xorshift32
//   One 32-bit xorshift32 PRNG state for share K of the encoder.
//   Ports:
//     clk, rst_n  - clock, async active-low reset (state resets to 32'h1)
//     load_i      - load seed_i ^ (K * spread) (zero mapped to 32'h1)
//     step_i      - advance one xorshift32 step (load has priority)
//     seed_i      - 32-bit seed
//     nib_o       - low nibble of the current state (share randomness)
// ----------------------------------------------------------------------------
module msk_xorshift32
    import msk_enc_pkg::*;
#(
    parameter int unsigned K = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] seed_i,
    output logic [3:0]  nib_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = xorshift32_seed(seed_i, 32'(K));
        end else if (step_i) begin
            state_d = xorshift32_next(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ZERO_FALLBACK;
        end else begin
            state_q <= state_d;
        end
    end

    assign nib_o = state_q[3:0];

endmodule

// File: rtl/msk_g16_share_encoder.sv
// ----------------------------------------------------------------------------
// msk_g16_share_encoder
//   Converts unmasked 4-bit nibbles into fresh d-share Boolean sharings in
//   bit-sliced form (outb[k] = bit b of share k). Shares 1..d-1 come from
//   per-share xorshift32 generators; share 0 = in_data ^ XOR of the others.
//   Ports:
//     clk, rst_n            - clock, async active-low reset
//     seed, seed_valid      - PRNG seed load (load wins over step)
//     in_data/valid/ready   - unmasked nibble input handshake
//     out0..out3            - bit-sliced sharing, d bits each
//     out_valid/out_ready   - output handshake
//   Optional macro MSK_ENC_DBG_UNMASK_EN (simulation only): adds output
//   dbg_unmasked (recombined held sharing) and a matching assertion.
// ----------------------------------------------------------------------------
module msk_g16_share_encoder
    import msk_enc_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  seed,
    input  logic         seed_valid,
    input  logic [3:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [d-1:0] out0,
    output logic [d-1:0] out1,
    output logic [d-1:0] out2,
    output logic [d-1:0] out3,
    output logic         out_valid,
    input  logic         out_ready
`ifdef MSK_ENC_DBG_UNMASK_EN
    ,
    output logic [3:0]   dbg_unmasked
`endif
);

    logic           seeded_q, seeded_d;
    logic           out_valid_q, out_valid_d;
    logic [d-1:0]   out0_q, out1_q, out2_q, out3_q;
    logic [d-1:0]   out0_d, out1_d, out2_d, out3_d;
    logic           accept;
    logic [3:0]     rnd   [1:d-1];
    logic [3:0]     share [d];

    assign in_ready = seeded_q && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar k = 1; k < d; k++) begin : g_prng
        msk_xorshift32 #(.K(k)) u_prng (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (seed_valid),
            .step_i (accept),
            .seed_i (seed),
            .nib_o  (rnd[k])
        );
    end

    always_comb begin
        share[0] = in_data;
        for (int unsigned k = 1; k < d; k++) begin
            share[k] = rnd[k];
            share[0] = share[0] ^ rnd[k];
        end
    end

    always_comb begin
        seeded_d    = seeded_q | seed_valid;
        out_valid_d = out_valid_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out3_d      = out3_q;
        if (accept) begin
            out_valid_d = 1'b1;
            for (int unsigned k = 0; k < d; k++) begin
                out0_d[k] = share[k][0];
                out1_d[k] = share[k][1];
                out2_d[k] = share[k][2];
                out3_d[k] = share[k][3];
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeded_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
        end else begin
            seeded_q    <= seeded_d;
            out_valid_q <= out_valid_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out3_q      <= out3_d;
        end
    end

    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out3      = out3_q;
    assign out_valid = out_valid_q;

`ifdef MSK_ENC_DBG_UNMASK_EN
    logic [3:0] dbg_ref_q;

    always_comb begin
        dbg_unmasked = '0;
        for (int unsigned k = 0; k < d; k++) begin
            dbg_unmasked = dbg_unmasked ^ {out3_q[k], out2_q[k], out1_q[k], out0_q[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_ref_q <= '0;
        end else if (accept) begin
            dbg_ref_q <= in_data;
        end
    end

    a_dbg_unmask : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q |-> (dbg_unmasked == dbg_ref_q));
`endif

endmodule

// File: doc/msk_g16_share_encoder.md
# msk_g16_share_encoder

Masked-domain entry point for G(16) datapaths. Accepts unmasked 4-bit nibbles over a valid/ready handshake and emits fresh d-share Boolean sharings in the bit-sliced format that downstream masked G(16) gadgets consume: one `[d-1:0]` bus per nibble bit. Share randomness comes from an internal, seedable xorshift32 bank. Sits between plaintext/key loading logic and the first masked stage of a cipher core.

## Interface
- `d`, default `DEFAULTSHARES` (2): number of shares, d >= 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `seed`  in  32  PRNG seed.
- `seed_valid`  in  1  load `seed` this cycle.
- `in_data`  in  4  unmasked nibble; bit b is coefficient b.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  encoder accepts this cycle.
- `out0`..`out3`  out  d each  sharing; `outb[k]` is bit b of share k.
- `out_valid`  out  1  sharing valid.
- `out_ready`  in  1  sink accepts.

## Operation
- PRNG bank: d-1 independent xorshift32 states `s_k`, k = 1..d-1.
  - Step: `x ^= x<<13; x ^= x>>17; x ^= x<<5`.
  - On `seed_valid`, load `s_k = seed ^ (k * 32'h9E3779B9)` (mod 2^32). If that value is 0, load 32'h1.
- Encode on accept (`in_valid && in_ready`):
  - Share k (k >= 1) = `s_k[3:0]`.
  - Share 0 = `in_data ^ XOR_k s_k[3:0]`.
  - All d shares are registered into `out*`, `out_valid` is set, and every `s_k` steps once.
- The PRNG steps only on accept, so no nibble of randomness is used twice.
- A `seeded` flag clears on reset and sets on the first `seed_valid`.
  - `in_ready = seeded && (!out_valid || out_ready)`.
  - Before seeding, no input is accepted.
- Output handshake:
  - `out_valid` falls on `out_ready` unless a new accept happens in the same cycle.
  - `out*` hold stable while `out_valid && !out_ready`.
- Simultaneous `seed_valid` and accept: the encode uses the pre-seed states. The load takes priority over the step, so next states = freshly seeded values.
- `seed_valid` while `out_valid` is held does not disturb the held output.
- The unmasked `in_data` is never stored; only shares are registered.

## Timing
- Latency 1: a nibble accepted at edge n is visible on `out*` with `out_valid` after edge n.
- Throughput: 1 nibble/cycle when `out_ready` is held high.
- Reset values (async, immediate on `rst_n` low):
  - `out_valid` = 0; `out0`..`out3` = 0; `in_ready` = 0.
  - `seeded` = 0; all `s_k` = 32'h1.
- Reset mid-transfer discards the held sharing; a reseed is required afterwards.
- `seed_valid` takes effect at the next edge; an accept is possible in the same cycle only if already seeded.

## Configuration
- `MSK_ENC_DBG_UNMASK_EN`
  - Defined: adds output `dbg_unmasked` [3:0] = XOR over k of share k of the currently held `out*`, and a simulation assertion that it matches the accepted `in_data`. For simulation only; never define in synthesis or leakage-verification builds.
  - Undefined: the port and the check are absent. The encoder never recombines shares.

## Structure
- Shared package `msk_enc_pkg` holds:
  - xorshift shift constants (13, 17, 5);
  - the seed-spread constant 32'h9E3779B9;
  - the zero-state fallback 32'h1;
  - a `xorshift32_next` function.
- Sub-module `msk_xorshift32`: one 32-bit state register with load/step enables and async reset to 32'h1. Instantiate it d-1 times in a generate loop.
- Top level holds the `seeded` flag, the output register, the handshake logic and the share-0 XOR tree.

## Test plan
- **Reset:** `rst_n` low mid-stream → `out_valid`, `in_ready`, `out*` = 0 immediately; `in_valid` is ignored until `seed_valid`.
- **First encode:** d=2, seed 32'h1 (`s_1` = 32'h9E3779B8), then `in_data` 4'hA → next cycle share1 = 4'h8, share0 = 4'h2, i.e. `out3` = 2'b10, `out1` = 2'b01, `out0` = `out2` = 2'b00.
- **Back-pressure:** `out_ready` low for 3 cycles with `in_valid` high → `in_ready` = 0, `out*` stable, exactly one nibble accepted. Releasing `out_ready` resumes 1/cycle.
- **Streaming:** d=3, 64 random nibbles, `out_ready` high → XOR of shares equals input in order. Shares 1 and 2 match a golden xorshift32 model stepped once per nibble.
- **Seed/accept collision:** `seed_valid` and accept in the same cycle → output uses the old states; the next output uses the new seed's `s_k[3:0]`.
- **Zero-seed fallback:** d=2, seed = 32'h9E3779B9 → `s_1` loads 32'h1; the first encode of 4'h0 gives share1 = 4'h1, share0 = 4'h1.
